fft_unloader: RTL and testbench

- Streaming reader on the output side of the combinational 16-point radix-2 DIT FFT.
- The FFT presents a full parallel frame in bit-reversed order, complex Q1.15.
- This block captures one frame per valid/ready handshake and emits it one complex sample per handshake in natural frequency order (bin 0 .. POINT_FFT-1).
- It tags each sample with its bin index and a last flag for downstream serial consumers.

---
 rtl/fft_unloader.sv | 80 ++++++++
 tb/tb_fft_unloader.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_unloader.sv
// Serialises one bit-reversed parallel FFT frame into natural-order complex samples.
// Optional macro FFT_UNLOADER_MAG_EN adds an |Re|+|Im| magnitude output (mag_o).
module fft_unloader #(
  parameter int POINT_FFT_POW2 = 4,
  parameter int FRAC_BITS      = 15,
  localparam int POINT_FFT     = 1 << POINT_FFT_POW2
) (
  input  logic                                        clk_i,
  input  logic                                        rst_i,
  input  logic                                        frame_valid_i,
  output logic                                        frame_ready_o,
  input  logic signed [POINT_FFT-1:0][1:0][FRAC_BITS:0] frame_i,
  output logic                                        sample_valid_o,
  input  logic                                        sample_ready_i,
  output logic signed [1:0][FRAC_BITS:0]              sample_o,
  output logic [POINT_FFT_POW2-1:0]                   sample_idx_o,
  output logic                                        sample_last_o
`ifdef FFT_UNLOADER_MAG_EN
  ,
  output logic [FRAC_BITS+1:0]                        mag_o
`endif
);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] STREAM = 1'b1;
  localparam logic [POINT_FFT_POW2-1:0] LAST_IDX = POINT_FFT_POW2'(POINT_FFT - 1);

  logic [0:0]                            state_reg;
  logic [POINT_FFT_POW2-1:0]             idx_reg;
  logic [POINT_FFT-1:0][1:0][FRAC_BITS:0] buf_reg;
  logic [POINT_FFT_POW2-1:0]             rev_idx;
  logic                                  capture;
  logic                                  sample_hs;

  // Buffer slot holding natural bin idx is the bit-reversed idx.
  generate
    for (genvar gi = 0; gi < POINT_FFT_POW2; gi++) begin : g_rev
      assign rev_idx[gi] = idx_reg[POINT_FFT_POW2-1-gi];
    end
  endgenerate

  assign sample_valid_o = (state_reg == STREAM);
  assign sample_idx_o   = idx_reg;
  assign sample_last_o  = sample_valid_o && (idx_reg == LAST_IDX);
  assign sample_o       = sample_valid_o ? buf_reg[rev_idx] : '0;
  // Ready in STREAM is combinational so the next frame lands with no bubble.
  assign frame_ready_o  = (state_reg == IDLE) || (sample_last_o && sample_ready_i);
  assign capture        = frame_valid_i && frame_ready_o;
  assign sample_hs      = sample_valid_o && sample_ready_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg <= IDLE;
      idx_reg   <= '0;
      buf_reg   <= '0;
    end else if (capture) begin
      buf_reg   <= frame_i;
      idx_reg   <= '0;
      state_reg <= STREAM;
    end else if (sample_hs) begin
      if (idx_reg == LAST_IDX) begin
        state_reg <= IDLE;
        idx_reg   <= '0;
      end else begin
        idx_reg <= idx_reg + 1'b1;
      end
    end
  end

`ifdef FFT_UNLOADER_MAG_EN
  logic [FRAC_BITS:0] re_abs;
  logic [FRAC_BITS:0] im_abs;

  // The most negative value negates to itself, which read unsigned is its exact magnitude.
  assign re_abs = sample_o[0][FRAC_BITS] ? (~sample_o[0] + 1'b1) : sample_o[0];
  assign im_abs = sample_o[1][FRAC_BITS] ? (~sample_o[1] + 1'b1) : sample_o[1];
  assign mag_o  = {1'b0, re_abs} + {1'b0, im_abs};
`endif

endmodule

// File: tb/tb_fft_unloader.sv
// Directed bench for fft_unloader: ordering, stall, back-to-back frames, async reset,
// continuous streaming, and (with FFT_UNLOADER_MAG_EN) the magnitude output.
module tb_fft_unloader;

  logic clk = 1'b0;
  logic rst_i;
  logic frame_valid_i;
  logic frame_ready_o;
  logic signed [15:0][1:0][15:0] frame_i;
  logic sample_valid_o;
  logic sample_ready_i;
  logic signed [1:0][15:0] sample_o;
  logic [3:0] sample_idx_o;
  logic sample_last_o;
`ifdef FFT_UNLOADER_MAG_EN
  logic [16:0] mag_o;
`endif

  int total = 0;
  int bad   = 0;

  fft_unloader #(.POINT_FFT_POW2(4), .FRAC_BITS(15)) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .frame_valid_i  (frame_valid_i),
    .frame_ready_o  (frame_ready_o),
    .frame_i        (frame_i),
    .sample_valid_o (sample_valid_o),
    .sample_ready_i (sample_ready_i),
    .sample_o       (sample_o),
    .sample_idx_o   (sample_idx_o),
    .sample_last_o  (sample_last_o)
`ifdef FFT_UNLOADER_MAG_EN
    ,
    .mag_o          (mag_o)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic rdy;
    int   idx;
    int   re;
    int   im;
    logic last;
    logic fr;
  } vec_t;

  vec_t tbl[16];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int re_of();
    return int'($signed(sample_o[0]));
  endfunction

  function automatic int im_of();
    return int'($signed(sample_o[1]));
  endfunction

  task automatic load_ramp();
    for (int p = 0; p < 16; p++) begin
      frame_i[p][0] = 16'(100 * p);
      frame_i[p][1] = 16'(-p);
    end
  endtask

  // Present a frame for one cycle while in IDLE.
  task automatic send_frame();
    frame_valid_i = 1'b1;
    #1;
    chk("accept_ready", int'(frame_ready_o), 1);
    tick();
    frame_valid_i = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    sample_ready_i = 1'b1;
    frame_valid_i  = 1'b0;
    #1;
    while (sample_valid_o && n < 40) begin
      tick();
      n++;
    end
    chk("drain_timeout", int'(sample_valid_o), 0);
  endtask

  initial begin
    int br_tab[16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};
    int accepts;
    for (int i = 0; i < 16; i++) begin
      tbl[i].rdy  = 1'b1;
      tbl[i].idx  = i;
      tbl[i].re   = 100 * br_tab[i];
      tbl[i].im   = -br_tab[i];
      tbl[i].last = (i == 15);
      tbl[i].fr   = (i == 15);
    end

    rst_i = 1'b1;
    frame_valid_i = 1'b0;
    sample_ready_i = 1'b0;
    frame_i = '0;
    #12;
    chk("rst_valid", int'(sample_valid_o), 0);
    chk("rst_re", re_of(), 0);
    chk("rst_idx", int'(sample_idx_o), 0);
    chk("rst_last", int'(sample_last_o), 0);
    rst_i = 1'b0;
    tick();
    chk("rst_ready", int'(frame_ready_o), 1);

    // Table-driven full-frame ordering.
    load_ramp();
    sample_ready_i = 1'b1;
    send_frame();
    for (int i = 0; i < 16; i++) begin
      sample_ready_i = tbl[i].rdy;
      #1;
      $display("vec n=%0d idx=%0d re=%0d im=%0d last=%0d", i, sample_idx_o, re_of(), im_of(), sample_last_o);
      chk("tbl_valid", int'(sample_valid_o), 1);
      chk("tbl_idx", int'(sample_idx_o), tbl[i].idx);
      chk("tbl_re", re_of(), tbl[i].re);
      chk("tbl_im", im_of(), tbl[i].im);
      chk("tbl_last", int'(sample_last_o), int'(tbl[i].last));
      chk("tbl_fready", int'(frame_ready_o), int'(tbl[i].fr));
      tick();
    end
    chk("idle_valid", int'(sample_valid_o), 0);
    chk("idle_ready", int'(frame_ready_o), 1);
    chk("idle_idx", int'(sample_idx_o), 0);
    chk("idle_last", int'(sample_last_o), 0);

    // Stall at n=5 for three cycles.
    send_frame();
    for (int i = 0; i < 5; i++) tick();
    sample_ready_i = 1'b0;
    for (int c = 0; c < 4; c++) begin
      if (c == 3) sample_ready_i = 1'b1;
      #1;
      $display("stall c=%0d idx=%0d re=%0d im=%0d", c, sample_idx_o, re_of(), im_of());
      chk("stall_valid", int'(sample_valid_o), 1);
      chk("stall_idx", int'(sample_idx_o), 5);
      chk("stall_re", re_of(), 1000);
      chk("stall_im", im_of(), -10);
      tick();
    end
    chk("post_stall_idx", int'(sample_idx_o), 6);
    chk("post_stall_re", re_of(), 600);
    chk("post_stall_im", im_of(), -6);
    drain();

    // Back-to-back: second frame (all Re=7) held valid from cycle 2.
    send_frame();
    tick();
    for (int p = 0; p < 16; p++) begin
      frame_i[p][0] = 16'sd7;
      frame_i[p][1] = 16'sd0;
    end
    frame_valid_i = 1'b1;
    for (int i = 1; i < 16; i++) begin
      #1;
      $display("b2b n=%0d idx=%0d re=%0d fready=%0d", i, sample_idx_o, re_of(), frame_ready_o);
      chk("b2b_idx", int'(sample_idx_o), i);
      chk("b2b_re", re_of(), tbl[i].re);
      chk("b2b_fready", int'(frame_ready_o), int'(i == 15));
      tick();
    end
    frame_valid_i = 1'b0;
    #1;
    chk("b2b_next_valid", int'(sample_valid_o), 1);
    chk("b2b_next_idx", int'(sample_idx_o), 0);
    chk("b2b_next_re", re_of(), 7);
    drain();

    // Asynchronous reset at n=9.
    load_ramp();
    send_frame();
    for (int i = 0; i < 9; i++) tick();
    chk("pre_rst_idx", int'(sample_idx_o), 9);
    rst_i = 1'b1;
    #1;
    $display("async rst valid=%0d idx=%0d", sample_valid_o, sample_idx_o);
    chk("async_rst_valid", int'(sample_valid_o), 0);
    chk("async_rst_re", re_of(), 0);
    tick();
    rst_i = 1'b0;
    tick();
    chk("after_rst_ready", int'(frame_ready_o), 1);
    chk("after_rst_idx", int'(sample_idx_o), 0);
    send_frame();
    chk("restart_idx", int'(sample_idx_o), 0);
    chk("restart_re", re_of(), 0);
    tick();
    chk("restart_n1_re", re_of(), 800);
    drain();

    // Continuous frame_valid: one accept per 16 samples, idx wraps.
    frame_valid_i = 1'b1;
    send_frame();
    frame_valid_i = 1'b1;
    accepts = 0;
    for (int c = 0; c < 48; c++) begin
      #1;
      chk("cont_valid", int'(sample_valid_o), 1);
      chk("cont_idx", int'(sample_idx_o), c % 16);
      if (frame_ready_o) accepts++;
      tick();
    end
    $display("continuous accepts=%0d", accepts);
    chk("cont_accepts", accepts, 3);
    drain();

`ifdef FFT_UNLOADER_MAG_EN
    chk("mag_idle", int'(mag_o), 0);
    frame_i = '0;
    frame_i[0][0] = -16'sd32768;
    frame_i[0][1] = -16'sd32768;
    frame_i[8][0] = 16'sd30274;
    frame_i[8][1] = -16'sd12540;
    send_frame();
    $display("mag n=0 mag=%0d", mag_o);
    chk("mag_max", int'(mag_o), 65536);
    tick();
    $display("mag n=1 mag=%0d", mag_o);
    chk("mag_mixed", int'(mag_o), 42814);
    drain();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
